// File: rtl/alu_ops_pkg.sv
// Shared ALU operation-code constants and execution FSM encoding.
// Used by the ALU control decoder and by alu_multicycle_exec.
package alu_ops_pkg;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_NOR = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0011;
  localparam logic [3:0] OP_SUB = 4'b0100;
  localparam logic [3:0] OP_LUI = 4'b0101;
  localparam logic [3:0] OP_JAL = 4'b0110;
  localparam logic [3:0] OP_SLL = 4'b0111;
  localparam logic [3:0] OP_SRL = 4'b1000;

  // Every code at or above this value is undefined.
  localparam logic [3:0] OP_ILLEGAL_MIN = 4'b1001;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } exec_state_e;

  function automatic logic op_is_shift(input logic [3:0] op);
    return (op == OP_SLL) || (op == OP_SRL);
  endfunction

  function automatic logic op_is_illegal(input logic [3:0] op);
    return op >= OP_ILLEGAL_MIN;
  endfunction

endpackage

// File: rtl/alu_shift_iter.sv
// Iterative one-bit-per-cycle shifter: shift register, down-counter and
// a done indication on the final shift. Zeros are shifted in.
module alu_shift_iter
  import alu_ops_pkg::*;
#(
  parameter int N_BITS  = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               shift_left,
  input  logic [N_BITS-1:0]  load_data,
  input  logic [SHAMT_W-1:0] load_amt,
  output logic [N_BITS-1:0]  shift_data,
  output logic               done
);

  logic [N_BITS-1:0]  data_q, data_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic               left_q, left_d;

  // shift_data is the register value after this cycle's shift; it is the
  // final result in the cycle where done is high.
  assign shift_data = left_q ? (data_q << 1) : (data_q >> 1);
  assign done       = (cnt_q == SHAMT_W'(1));

  // Load on request, otherwise shift and count down while the count is nonzero.
  always_comb begin
    data_d = data_q;
    cnt_d  = cnt_q;
    left_d = left_q;
    if (load) begin
      data_d = load_data;
      cnt_d  = load_amt;
      left_d = shift_left;
    end else if (cnt_q != '0) begin
      data_d = shift_data;
      cnt_d  = cnt_q - SHAMT_W'(1);
    end
  end

  // Shift state registers; reset abandons any shift in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= '0;
      cnt_q  <= '0;
      left_q <= 1'b0;
    end else begin
      data_q <= data_d;
      cnt_q  <= cnt_d;
      left_q <= left_d;
    end
  end

endmodule

// File: rtl/alu_multicycle_exec.sv
// Multi-cycle ALU execution stage consuming the 4-bit ALUOperation code.
// Configuration macro: ALU_FAST_SHIFT_EN -- when defined, SLL/SRL use a
// combinational barrel shifter and every legal op completes in one cycle.
//
// state | meaning
// IDLE  | ready for a new request (op_ready=1)
// SHIFT | iterative shifter running, one bit per cycle
// DONE  | result held with result_valid=1 until result_ready
module alu_multicycle_exec
  import alu_ops_pkg::*;
#(
  parameter int N_BITS  = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               op_valid,
  output logic               op_ready,
  input  logic [3:0]         alu_operation,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [N_BITS-1:0]  operand_a,
  input  logic [N_BITS-1:0]  operand_b,
  output logic               result_valid,
  input  logic               result_ready,
  output logic [N_BITS-1:0]  result,
  output logic               zero,
  output logic               illegal_op
);

  exec_state_e       state_q, state_d;
  logic              op_ready_q, op_ready_d;
  logic              result_valid_q, result_valid_d;
  logic [N_BITS-1:0] result_q, result_d;
  logic              zero_q, zero_d;
  logic              illegal_q, illegal_d;
  logic [N_BITS-1:0] single_res;

  // Shift ops fall through to operand B here: that is the shamt==0 result.
  function automatic logic [N_BITS-1:0] alu_single_step(
    input logic [3:0]        op,
    input logic [N_BITS-1:0] a,
    input logic [N_BITS-1:0] b
  );
    logic [N_BITS-1:0] r;
    case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_NOR:  r = ~(a | b);
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_LUI:  r = {b[15:0], {(N_BITS-16){1'b0}}};
      OP_JAL:  r = a + N_BITS'(4);
      OP_SLL:  r = b;
      OP_SRL:  r = b;
      default: r = '0;
    endcase
    return r;
  endfunction

`ifndef ALU_FAST_SHIFT_EN
  logic              shift_load;
  logic [N_BITS-1:0] shift_data;
  logic              shift_done;

  alu_shift_iter #(
    .N_BITS  (N_BITS),
    .SHAMT_W (SHAMT_W)
  ) u_shift (
    .clk        (clk),
    .reset      (reset),
    .load       (shift_load),
    .shift_left (alu_operation == OP_SLL),
    .load_data  (operand_b),
    .load_amt   (shamt),
    .shift_data (shift_data),
    .done       (shift_done)
  );
`endif

  // Next-state, result capture and registered handshake outputs.
  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    zero_d    = zero_q;
    illegal_d = illegal_q;
    single_res = alu_single_step(alu_operation, operand_a, operand_b);
`ifdef ALU_FAST_SHIFT_EN
    if (alu_operation == OP_SLL) begin
      single_res = operand_b << shamt;
    end else if (alu_operation == OP_SRL) begin
      single_res = operand_b >> shamt;
    end
`else
    shift_load = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (op_valid) begin
          illegal_d = 1'b0;
          if (op_is_illegal(alu_operation)) begin
            result_d  = '0;
            zero_d    = 1'b1;
            illegal_d = 1'b1;
            state_d   = ST_DONE;
          end
`ifndef ALU_FAST_SHIFT_EN
          else if (op_is_shift(alu_operation) && (shamt != '0)) begin
            shift_load = 1'b1;
            state_d    = ST_SHIFT;
          end
`endif
          else begin
            result_d = single_res;
            zero_d   = (single_res == '0);
            state_d  = ST_DONE;
          end
        end
      end
      ST_SHIFT: begin
`ifndef ALU_FAST_SHIFT_EN
        if (shift_done) begin
          result_d = shift_data;
          zero_d   = (shift_data == '0);
          state_d  = ST_DONE;
        end
`else
        state_d = ST_IDLE;
`endif
      end
      ST_DONE: begin
        if (result_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    op_ready_d     = (state_d == ST_IDLE);
    result_valid_d = (state_d == ST_DONE);
  end

  // FSM and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      op_ready_q     <= 1'b1;
      result_valid_q <= 1'b0;
      result_q       <= '0;
      zero_q         <= 1'b0;
      illegal_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      op_ready_q     <= op_ready_d;
      result_valid_q <= result_valid_d;
      result_q       <= result_d;
      zero_q         <= zero_d;
      illegal_q      <= illegal_d;
    end
  end

  assign op_ready     = op_ready_q;
  assign result_valid = result_valid_q;
  assign result       = result_q;
  assign zero         = zero_q;
  assign illegal_op   = illegal_q;

endmodule

// File: tb/tb_alu_multicycle_exec.sv
// Scoreboard bench for alu_multicycle_exec: the driver pushes expected
// responses, the monitor pops and compares when result_valid rises.
module tb_alu_multicycle_exec;

  logic        clk = 1'b0;
  logic        reset;
  logic        op_valid;
  logic        op_ready;
  logic [3:0]  alu_operation;
  logic [4:0]  shamt;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic        result_valid;
  logic        result_ready;
  logic [31:0] result;
  logic        zero;
  logic        illegal_op;

  alu_multicycle_exec #(.N_BITS(32), .SHAMT_W(5)) dut (
    .clk           (clk),
    .reset         (reset),
    .op_valid      (op_valid),
    .op_ready      (op_ready),
    .alu_operation (alu_operation),
    .shamt         (shamt),
    .operand_a     (operand_a),
    .operand_b     (operand_b),
    .result_valid  (result_valid),
    .result_ready  (result_ready),
    .result        (result),
    .zero          (zero),
    .illegal_op    (illegal_op)
  );

  always #5 clk = ~clk;

`ifdef ALU_FAST_SHIFT_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  typedef struct {
    logic [31:0] res;
    logic        zero;
    logic        ill;
    int          lat;
    int          acc;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    hold_q[$];
  int    cyc = 0;
  int    checks = 0;
  int    errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  function automatic int shift_lat(input int sh);
    return FAST ? 1 : sh + 1;
  endfunction

  task automatic issue(input string nm, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] sh, input logic [31:0] er,
                       input logic ez, input logic ei, input int lat, input int hold);
    int   guard;
    exp_t e;
    guard = 0;
    @(negedge clk);
    while (!op_ready && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    if (!op_ready) begin
      checks++;
      errors++;
      $display("FAIL %s op_ready timeout: got 0 expected 1", nm);
      return;
    end
    op_valid = 1'b1;
    alu_operation = op;
    operand_a = a;
    operand_b = b;
    shamt = sh;
    e.res = er; e.zero = ez; e.ill = ei; e.lat = lat; e.acc = cyc;
    exp_q.push_back(e);
    name_q.push_back(nm);
    hold_q.push_back(hold);
    @(negedge clk);
    op_valid = 1'b0;
    alu_operation = 4'($urandom);
    operand_a = $urandom;
    operand_b = $urandom;
    shamt = 5'($urandom);
  endtask

  // Monitor: pop on result_valid rising, then check the result stays put.
  initial begin : monitor
    exp_t  cur;
    string nm;
    bit    have;
    have = 1'b0;
    cur.res = '0; cur.zero = 1'b0; cur.ill = 1'b0; cur.lat = 0; cur.acc = 0;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        have = 1'b0;
      end else if (result_valid && !have) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got %h expected none", result);
        end else begin
          cur = exp_q.pop_front();
          nm = name_q.pop_front();
          chk({nm, " result"}, result, cur.res);
          chk({nm, " zero"}, 32'(zero), 32'(cur.zero));
          chk({nm, " illegal_op"}, 32'(illegal_op), 32'(cur.ill));
          chk({nm, " latency"}, 32'(cyc - cur.acc), 32'(cur.lat));
        end
        have = 1'b1;
      end else if (result_valid && have) begin
        chk({nm, " held result"}, result, cur.res);
        chk({nm, " op_ready while held"}, 32'(op_ready), 32'd0);
      end else begin
        have = 1'b0;
      end
    end
  end

  // Sink: consume each result after its requested number of stall cycles.
  initial begin : sink
    int wait_cnt;
    wait_cnt = 0;
    result_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (result_valid && hold_q.size() > 0) begin
        if (wait_cnt >= hold_q[0]) begin
          result_ready = 1'b1;
          void'(hold_q.pop_front());
          wait_cnt = 0;
        end else begin
          result_ready = 1'b0;
          wait_cnt++;
        end
      end else begin
        result_ready = 1'b0;
        wait_cnt = 0;
      end
    end
  end

  initial begin : driver
    int guard;
    reset = 1'b1;
    op_valid = 1'b0;
    alu_operation = '0;
    shamt = '0;
    operand_a = '0;
    operand_b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset op_ready", 32'(op_ready), 32'd1);
    chk("reset result_valid", 32'(result_valid), 32'd0);
    chk("reset result", result, 32'h0);
    chk("reset zero", 32'(zero), 32'd0);
    chk("reset illegal_op", 32'(illegal_op), 32'd0);
    reset = 1'b0;

    issue("add_wrap", 4'b0011, 32'h7FFF_FFFF, 32'h1, 5'd0, 32'h8000_0000, 1'b0, 1'b0, 1, 3);
    issue("sub_zero", 4'b0100, 32'h1234_5678, 32'h1234_5678, 5'd0, 32'h0, 1'b1, 1'b0, 1, 0);
    issue("lui", 4'b0101, 32'h5555_5555, 32'h0000_ABCD, 5'd0, 32'hABCD_0000, 1'b0, 1'b0, 1, 1);
    issue("sll31", 4'b0111, 32'h0, 32'h0000_0001, 5'd31, 32'h8000_0000, 1'b0, 1'b0, shift_lat(31), 0);
    issue("srl4", 4'b1000, 32'h0, 32'h8000_0000, 5'd4, 32'h0800_0000, 1'b0, 1'b0, shift_lat(4), 2);
    issue("srl0", 4'b1000, 32'h0, 32'hDEAD_BEEF, 5'd0, 32'hDEAD_BEEF, 1'b0, 1'b0, 1, 0);
    issue("illegal9", 4'b1001, 32'h1, 32'h2, 5'd0, 32'h0, 1'b1, 1'b1, 1, 0);
    issue("add_after_ill", 4'b0011, 32'h1, 32'h1, 5'd0, 32'h2, 1'b0, 1'b0, 1, 0);
    issue("sll1", 4'b0111, 32'h0, 32'h0000_0003, 5'd1, 32'h0000_0006, 1'b0, 1'b0, shift_lat(1), 0);
    issue("srl31", 4'b1000, 32'h0, 32'hFFFF_FFFF, 5'd31, 32'h0000_0001, 1'b0, 1'b0, shift_lat(31), 0);
    issue("or", 4'b0001, 32'h0F0F_0000, 32'h0000_00F0, 5'd0, 32'h0F0F_00F0, 1'b0, 1'b0, 1, 0);
    issue("nor", 4'b0010, 32'h0, 32'h0, 5'd0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1, 0);
    issue("jal", 4'b0110, 32'h0040_0000, 32'h1234_0000, 5'd0, 32'h0040_0004, 1'b0, 1'b0, 1, 0);
    issue("illegal15", 4'b1111, 32'hFFFF_FFFF, 32'h1, 5'd3, 32'h0, 1'b1, 1'b1, 1, 0);

    // Reset in the middle of a long shift: no result is expected from it.
    guard = 0;
    @(negedge clk);
    while (!op_ready && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    op_valid = 1'b1;
    alu_operation = 4'b0111;
    operand_b = 32'h1;
    shamt = 5'd20;
    @(negedge clk);
    op_valid = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("midreset op_ready", 32'(op_ready), 32'd1);
    chk("midreset result_valid", 32'(result_valid), 32'd0);
    chk("midreset result", result, 32'h0);
    chk("midreset zero", 32'(zero), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    issue("and_after_reset", 4'b0000, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0, 32'hF000_F000, 1'b0, 1'b0, 1, 0);
    issue("sll_after_reset", 4'b0111, 32'h0, 32'h0000_00FF, 5'd8, 32'h0000_FF00, 1'b0, 1'b0, shift_lat(8), 0);

    guard = 0;
    while ((exp_q.size() != 0 || result_valid) && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    if (exp_q.size() != 0 || result_valid) begin
      checks++;
      errors++;
      $display("FAIL drain timeout: pending=%0d expected 0", exp_q.size());
    end
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
